// File: rtl/vm_change_pkg.sv
// Shared encodings for the change dispenser: FSM state values and the coin
// codes driven to the hopper.
package vm_change_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_EJECT  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0] COIN_LO  = 2'd0;
  localparam logic [1:0] COIN_MID = 2'd1;
  localparam logic [1:0] COIN_HI  = 2'd2;

endpackage

// File: rtl/change_coin_select.sv
// Combinational greedy picker: chooses the largest denomination that still
// fits into the remaining amount and has at least one coin in its tube.
module change_coin_select
  import vm_change_pkg::*;
#(
  parameter int STOCK_WIDTH = 6
) (
  input  logic [6:0]             remaining,
  input  logic [STOCK_WIDTH-1:0] stock_hi,
  input  logic [STOCK_WIDTH-1:0] stock_mid,
  input  logic [STOCK_WIDTH-1:0] stock_lo,
  input  logic [6:0]             value_hi,
  input  logic [6:0]             value_mid,
  input  logic [6:0]             value_lo,
  output logic                   found,
  output logic [1:0]             coin,
  output logic [6:0]             value
);

  always_comb begin
    found = 1'b0;
    coin  = COIN_LO;
    value = 7'd0;
    if ((value_hi <= remaining) && (stock_hi != '0)) begin
      found = 1'b1;
      coin  = COIN_HI;
      value = value_hi;
    end else if ((value_mid <= remaining) && (stock_mid != '0)) begin
      found = 1'b1;
      coin  = COIN_MID;
      value = value_mid;
    end else if ((value_lo <= remaining) && (stock_lo != '0)) begin
      found = 1'b1;
      coin  = COIN_LO;
      value = value_lo;
    end
  end

endmodule

// File: rtl/vm_change_dispenser.sv
// Pays out a latched change amount one coin at a time through the hopper
// handshake, tracking per-tube stock and flagging any unpaid shortfall.
module vm_change_dispenser
  import vm_change_pkg::*;
#(
  parameter logic [6:0] COIN_HI_VALUE  = 7'd10,
  parameter logic [6:0] COIN_MID_VALUE = 7'd5,
  parameter logic [6:0] COIN_LO_VALUE  = 7'd1,
  parameter int         STOCK_WIDTH    = 6,
  parameter int         INIT_STOCK     = 20
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_load,
  input  logic [6:0]             i_change_value,
  input  logic                   i_refill,
  input  logic                   i_eject_ack,
  output logic                   o_eject_req,
  output logic [1:0]             o_eject_coin,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_short,
  output logic [6:0]             o_remaining,
  output logic [STOCK_WIDTH-1:0] o_stock_hi,
  output logic [STOCK_WIDTH-1:0] o_stock_mid,
  output logic [STOCK_WIDTH-1:0] o_stock_lo,
  output logic [1:0]             o_state
);

  localparam logic [STOCK_WIDTH-1:0] FULL_STOCK = STOCK_WIDTH'(INIT_STOCK);

  state_t                 state, state_next;
  logic [6:0]             remaining;
  logic [1:0]             coin;
  logic [6:0]             coin_value;
  logic [STOCK_WIDTH-1:0] stock_hi, stock_mid, stock_lo;

  logic                   sel_found;
  logic [1:0]             sel_coin;
  logic [6:0]             sel_value;

  change_coin_select #(
    .STOCK_WIDTH(STOCK_WIDTH)
  ) u_select (
    .remaining(remaining),
    .stock_hi (stock_hi),
    .stock_mid(stock_mid),
    .stock_lo (stock_lo),
    .value_hi (COIN_HI_VALUE),
    .value_mid(COIN_MID_VALUE),
    .value_lo (COIN_LO_VALUE),
    .found    (sel_found),
    .coin     (sel_coin),
    .value    (sel_value)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (i_load) state_next = ST_SELECT;
      ST_SELECT: state_next = sel_found ? ST_EJECT : ST_DONE;
      ST_EJECT:  if (i_eject_ack) state_next = ST_SELECT;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  // The coin value is captured alongside the code so the ack path needs no re-decode.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      remaining  <= 7'd0;
      coin       <= COIN_LO;
      coin_value <= 7'd0;
      stock_hi   <= FULL_STOCK;
      stock_mid  <= FULL_STOCK;
      stock_lo   <= FULL_STOCK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_refill) begin
            stock_hi  <= FULL_STOCK;
            stock_mid <= FULL_STOCK;
            stock_lo  <= FULL_STOCK;
          end
          if (i_load) remaining <= i_change_value;
        end
        ST_SELECT: begin
          if (sel_found) begin
            coin       <= sel_coin;
            coin_value <= sel_value;
          end
        end
        ST_EJECT: begin
          if (i_eject_ack) begin
            remaining <= remaining - coin_value;
            case (coin)
              COIN_HI:  stock_hi  <= stock_hi - 1'b1;
              COIN_MID: stock_mid <= stock_mid - 1'b1;
              default:  stock_lo  <= stock_lo - 1'b1;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign o_eject_req  = (state == ST_EJECT);
  assign o_eject_coin = coin;
  assign o_busy       = (state != ST_IDLE);
  assign o_done       = (state == ST_DONE);
  assign o_short      = (state == ST_DONE) && (remaining != 7'd0);
  assign o_remaining  = remaining;
  assign o_stock_hi   = stock_hi;
  assign o_stock_mid  = stock_mid;
  assign o_stock_lo   = stock_lo;
  assign o_state      = state;

endmodule
